// File: rtl/renkon_ctrl_pool_stride_if.sv
// Control bus shared by the renkon pooling stages: one start, valid and stop
// strobe per raster stream.
interface ctrl_bus;
  logic start;
  logic valid;
  logic stop;

  modport master (output start, output valid, output stop);
  modport slave  (input start, input valid, input stop);
endinterface

// File: rtl/renkon_ctrl_pool_stride.sv
// Pooling controller with independent runtime window size and stride; turns the
// raster input control stream into the delayed pooled-output control stream.
module renkon_ctrl_pool_stride #(
  parameter int LWIDTH = 16,
  parameter int D_POOL = 2
) (
  input  logic              clk,
  input  logic              xrst,
  ctrl_bus.slave            in_ctrl,
  input  logic [LWIDTH-1:0] w_fea_size,
  input  logic [LWIDTH-1:0] w_pool_size,
  input  logic [LWIDTH-1:0] w_stride,
  ctrl_bus.master           out_ctrl,
  output logic              pool_oe,
  output logic [LWIDTH-1:0] pool_size,
  output logic              busy,
  output logic              cfg_err
);

  localparam logic [LWIDTH-1:0] ZERO = {LWIDTH{1'b0}};
  localparam logic [LWIDTH-1:0] ONE  = {{(LWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {S_WAIT = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [LWIDTH-1:0] fea_r, pool_r, stride_r;
  logic [LWIDTH-1:0] x_r, y_r, xph_r, yph_r;
  logic              start_f_r, win_f_r, last_f_r;
  logic [D_POOL-1:0] st_start_r, st_valid_r, st_stop_r;
  logic              cfg_ok_s, start_acc_s, cfg_bad_s, pix_s;
  logic              lastx_s, lasty_s, xin_s, yin_s, win_s, last_s;
  logic              unused_stop_s;

  // Phase of the next coordinate: held at 0 until the first window fits, then
  // cycles 0..S-1 so that phase 0 marks a window-aligned position.
  function automatic logic [LWIDTH-1:0] next_phase(input logic fits,
                                                   input logic [LWIDTH-1:0] ph,
                                                   input logic [LWIDTH-1:0] lim);
    logic [LWIDTH-1:0] r;
    if (!fits) begin
      r = ZERO;
    end else if (ph == lim) begin
      r = ZERO;
    end else begin
      r = ph + ONE;
    end
    return r;
  endfunction

  assign unused_stop_s = in_ctrl.stop;
  assign cfg_ok_s = (w_pool_size != ZERO) && (w_pool_size <= w_fea_size) && (w_stride != ZERO);

  // Next-state, start acceptance and window/last-pixel detection.
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    cfg_bad_s   = 1'b0;
    pix_s       = 1'b0;
    case (state_r)
      S_WAIT: begin
        if (in_ctrl.start) begin
          if (cfg_ok_s) begin
            start_acc_s = 1'b1;
            state_s     = S_ACTIVE;
          end else begin
            cfg_bad_s = 1'b1;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_ACTIVE: begin
        pix_s = in_ctrl.valid;
        if (st_stop_r[D_POOL-1]) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_ACTIVE;
        end
      end
      default: state_s = S_WAIT;
    endcase
    lastx_s = (x_r == fea_r - ONE);
    lasty_s = (y_r == fea_r - ONE);
    xin_s   = (x_r >= pool_r - ONE);
    yin_s   = (y_r >= pool_r - ONE);
    win_s   = pix_s && xin_s && (xph_r == ZERO) && yin_s && (yph_r == ZERO);
    last_s  = pix_s && lastx_s && lasty_s;
  end

  // FSM state, latched configuration and sticky configuration error.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_r  <= S_WAIT;
      fea_r    <= ZERO;
      pool_r   <= ZERO;
      stride_r <= ZERO;
      cfg_err  <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_acc_s) begin
        fea_r    <= w_fea_size;
        pool_r   <= w_pool_size;
        stride_r <= w_stride;
        cfg_err  <= 1'b0;
      end else if (cfg_bad_s) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Raster position and stride phase counters, stalled between valids.
  always_ff @(posedge clk) begin
    if (!xrst || state_r == S_WAIT) begin
      x_r   <= ZERO;
      y_r   <= ZERO;
      xph_r <= ZERO;
      yph_r <= ZERO;
    end else if (pix_s) begin
      if (lastx_s) begin
        x_r   <= ZERO;
        xph_r <= ZERO;
        y_r   <= lasty_s ? ZERO : y_r + ONE;
        yph_r <= lasty_s ? ZERO : next_phase(yin_s, yph_r, stride_r - ONE);
      end else begin
        x_r   <= x_r + ONE;
        xph_r <= next_phase(xin_s, xph_r, stride_r - ONE);
      end
    end
  end

  // Event flags and the free-running output delay line.
  always_ff @(posedge clk) begin
    if (!xrst) begin
      start_f_r  <= 1'b0;
      win_f_r    <= 1'b0;
      last_f_r   <= 1'b0;
      st_start_r <= {D_POOL{1'b0}};
      st_valid_r <= {D_POOL{1'b0}};
      st_stop_r  <= {D_POOL{1'b0}};
    end else begin
      start_f_r  <= start_acc_s;
      win_f_r    <= win_s;
      last_f_r   <= last_s;
      st_start_r <= {st_start_r[D_POOL-2:0], start_f_r};
      st_valid_r <= {st_valid_r[D_POOL-2:0], win_f_r};
      st_stop_r  <= {st_stop_r[D_POOL-2:0], last_f_r};
    end
  end

  assign out_ctrl.start = st_start_r[D_POOL-1];
  assign out_ctrl.valid = st_valid_r[D_POOL-1];
  assign out_ctrl.stop  = st_stop_r[D_POOL-1];
  assign pool_oe        = st_valid_r[D_POOL-2];
  assign pool_size      = pool_r;
  assign busy           = (state_r == S_ACTIVE);

endmodule
